// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: one-hot operation bit positions
// and the operation vector type.
package alu_pkg;

  localparam int OP_W = 12;

  typedef logic [OP_W-1:0] op_t;

  localparam int OP_ADD  = 11;
  localparam int OP_SUB  = 10;
  localparam int OP_SLT  = 9;
  localparam int OP_SLTU = 8;
  localparam int OP_AND  = 7;
  localparam int OP_NOR  = 6;
  localparam int OP_OR   = 5;
  localparam int OP_XOR  = 4;
  localparam int OP_SLL  = 3;
  localparam int OP_SRL  = 2;
  localparam int OP_SRA  = 1;
  localparam int OP_LUI  = 0;

endpackage

// File: rtl/alu_adder.sv
// Shared adder for add/sub/slt/sltu: computes a + (b or ~b) + cin and reports
// carry-out and signed overflow of that operation.
module alu_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             invert_b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  always_comb begin
    b_eff = invert_b ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    sum   = full[WIDTH-1:0];
    cout  = full[WIDTH];
    // Overflow: both addends share a sign that the sum does not.
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_total.sv
// Registered 32-bit integer ALU with a 12-bit one-hot operation select; every
// selected result is masked by its op bit and the terms are OR-ed together.
module alu_total
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  op_t              op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  localparam int SH_W = $clog2(WIDTH);

  logic             use_sub;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] slt_res;
  logic [WIDTH-1:0] sltu_res;
  logic [WIDTH-1:0] sll_res;
  logic [WIDTH-1:0] srl_res;
  logic [WIDTH-1:0] sra_res;
  logic [WIDTH-1:0] lui_res;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  // sub, slt and sltu all need in0 - in1 from the one adder.
  assign use_sub = op[OP_SUB] | op[OP_SLT] | op[OP_SLTU];

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .a        (in0),
    .b        (in1),
    .cin      (use_sub),
    .invert_b (use_sub),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always_comb begin
    shamt    = in0[SH_W-1:0];
    // Signed less-than is the true sign of a-b; unsigned is the borrow.
    slt_res  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
    sltu_res = {{(WIDTH-1){1'b0}}, ~cout};
    sll_res  = in1 << shamt;
    srl_res  = in1 >> shamt;
    sra_res  = $unsigned($signed(in1) >>> shamt);
    lui_res  = WIDTH'(in1[15:0]) << 16;

    out_d = ({WIDTH{op[OP_ADD]}}  & sum)
          | ({WIDTH{op[OP_SUB]}}  & sum)
          | ({WIDTH{op[OP_SLT]}}  & slt_res)
          | ({WIDTH{op[OP_SLTU]}} & sltu_res)
          | ({WIDTH{op[OP_AND]}}  & (in0 & in1))
          | ({WIDTH{op[OP_NOR]}}  & ~(in0 | in1))
          | ({WIDTH{op[OP_OR]}}   & (in0 | in1))
          | ({WIDTH{op[OP_XOR]}}  & (in0 ^ in1))
          | ({WIDTH{op[OP_SLL]}}  & sll_res)
          | ({WIDTH{op[OP_SRL]}}  & srl_res)
          | ({WIDTH{op[OP_SRA]}}  & sra_res)
          | ({WIDTH{op[OP_LUI]}}  & lui_res);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_alu_total.sv
// Bench for alu_total: directed cases with literal expectations, async reset,
// then back-to-back random operations checked against a behavioural model.
module tb_alu_total;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  op_t         op;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [31:0] out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  alu_total #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .op     (op),
    .in0    (in0),
    .in1    (in1),
    .out    (out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(op_t o, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    int sh;
    r  = 32'h0;
    sh = int'(a % 32);
    if (o[OP_ADD])  r |= a + b;
    if (o[OP_SUB])  r |= a - b;
    if (o[OP_SLT])  r |= ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    if (o[OP_SLTU]) r |= (a < b) ? 32'd1 : 32'd0;
    if (o[OP_AND])  r |= a & b;
    if (o[OP_NOR])  r |= ~(a | b);
    if (o[OP_OR])   r |= a | b;
    if (o[OP_XOR])  r |= a ^ b;
    if (o[OP_SLL])  r |= b << sh;
    if (o[OP_SRL])  r |= b >> sh;
    if (o[OP_SRA])  r |= $unsigned($signed(b) >>> sh);
    if (o[OP_LUI])  r |= (b % 65536) * 65536;
    return r;
  endfunction

  function automatic op_t onehot(int idx);
    op_t o;
    o = '0;
    o[idx] = 1'b1;
    return o;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input op_t o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op  = o;
    in0 = a;
    in1 = b;
  endtask

  task automatic directed(input string tag, input int idx, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    drive(onehot(idx), a, b);
    @(posedge clk);
    #1;
    check_eq(tag, out, exp);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic op_t rand_op();
    int k;
    k = $urandom_range(0, 19);
    if (k == 0) return '0;
    // Multi-hot limited to non-adder ops so each selected result is independent.
    if (k == 1) return op_t'($urandom_range(1, 255));
    return onehot($urandom_range(0, 11));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0;
    op     = '0;
    in0    = 32'h0;
    in1    = 32'h0;
    #2;
    check_eq("reset_out", out, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_held", out, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    directed("add_1_1",     OP_ADD,  32'h1,          32'h1,          32'h2);
    directed("sub_3_2",     OP_SUB,  32'h3,          32'h2,          32'h1);
    directed("add_wrap",    OP_ADD,  32'hFFFF_FFFF,  32'h1,          32'h0);
    directed("slt_1_2",     OP_SLT,  32'h1,          32'h2,          32'h1);
    directed("sltu_1_2",    OP_SLTU, 32'h1,          32'h2,          32'h1);
    directed("slt_m1_1",    OP_SLT,  32'hFFFF_FFFF,  32'h1,          32'h1);
    directed("sltu_m1_1",   OP_SLTU, 32'hFFFF_FFFF,  32'h1,          32'h0);
    directed("slt_ovf",     OP_SLT,  32'h8000_0000,  32'h7FFF_FFFF,  32'h1);
    directed("slt_ovf_rev", OP_SLT,  32'h7FFF_FFFF,  32'h8000_0000,  32'h0);
    directed("and",         OP_AND,  32'hA,          32'h5,          32'h0);
    directed("nor",         OP_NOR,  32'hA,          32'h5,          32'hFFFF_FFF0);
    directed("or",          OP_OR,   32'hA,          32'h5,          32'hF);
    directed("xor",         OP_XOR,  32'hB,          32'h5,          32'hE);
    directed("sll",         OP_SLL,  32'h4,          32'h1,          32'h10);
    directed("srl",         OP_SRL,  32'h8,          32'h8000_0000,  32'h0080_0000);
    directed("sra",         OP_SRA,  32'h4,          32'h8000_0000,  32'hF800_0000);
    directed("sra_amt_hi",  OP_SRA,  32'h24,         32'h8000_0000,  32'hF800_0000);
    directed("srl_out",     OP_SRL,  32'h8,          32'h2,          32'h0);
    directed("lui_a0",      OP_LUI,  32'h0,          32'hBFC0,       32'hBFC0_0000);
    directed("lui_a1234",   OP_LUI,  32'h1234,       32'hBFC0,       32'hBFC0_0000);

    drive('0, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk);
    #1;
    check_eq("op_zero", out, 32'h0);

    // Reset asserted between edges during an add must clear out immediately.
    directed("pre_reset_add", OP_ADD, 32'h10, 32'h20, 32'h30);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("async_clear", out, 32'h0);
    @(posedge clk);
    #1;
    check_eq("reset_hold_edge", out, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    op     = onehot(OP_SUB);
    in0    = 32'h9;
    in1    = 32'h4;
    @(posedge clk);
    #1;
    check_eq("first_after_reset", out, 32'h5);

    // Back-to-back random traffic: a new operation every cycle.
    for (int i = 0; i < 400; i++) begin
      op_t         o;
      logic [31:0] a;
      logic [31:0] b;
      o = rand_op();
      a = rand_operand();
      b = rand_operand();
      drive(o, a, b);
      exp_q.push_back(ref_alu(o, a, b));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check_eq("rand_queue_empty", 32'h1, 32'h0);
      end else begin
        check_eq("rand", out, exp_q.pop_front());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
